// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: six-state one-hot ring counter plus opcode decode
// producing the control word for fetch (T1-T3) and execute (T4-T6).
module sap1_controller_sequencer (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       RUN,
  input  logic [3:0] OPCODE,
  output logic [5:0] T,
  output logic       HLT,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm,
  output logic       CE,
  output logic       Li,
  output logic       Ei,
  output logic       La,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb,
  output logic       Lo
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Control word bit order: {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo}
  localparam logic [11:0] C_CP = 12'h800;
  localparam logic [11:0] C_EP = 12'h400;
  localparam logic [11:0] C_LM = 12'h200;
  localparam logic [11:0] C_CE = 12'h100;
  localparam logic [11:0] C_LI = 12'h080;
  localparam logic [11:0] C_EI = 12'h040;
  localparam logic [11:0] C_LA = 12'h020;
  localparam logic [11:0] C_EA = 12'h010;
  localparam logic [11:0] C_SU = 12'h008;
  localparam logic [11:0] C_EU = 12'h004;
  localparam logic [11:0] C_LB = 12'h002;
  localparam logic [11:0] C_LO = 12'h001;

  ring_t       ring;
  logic        halted;
  logic        ring_legal;
  logic [11:0] ctl;

  assign ring_legal = (ring != 6'b0) && ((ring & (ring - 6'd1)) == 6'b0);

  // Priority: CLR, then halt hold, then programming mode, then normal advance.
  // Halt entry freezes the ring on T4 so the halted state is visible on T.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      ring   <= T1;
      halted <= 1'b0;
    end else if (halted) begin
      ring   <= ring;
    end else if (!RUN || !ring_legal) begin
      ring   <= T1;
    end else if (ring == T4 && OPCODE == OP_HLT) begin
      halted <= 1'b1;
    end else begin
      ring   <= ring_t'({ring[4:0], ring[5]});
    end
  end

  always_comb begin
    ctl = 12'h000;
    if (RUN && !halted) begin
      case (ring)
        T1: ctl = C_EP | C_LM;
        T2: ctl = C_CP;
        T3: ctl = C_CE | C_LI;
        T4: begin
          case (OPCODE)
            OP_LDA, OP_ADD, OP_SUB: ctl = C_EI | C_LM;
            OP_OUT:                 ctl = C_EA | C_LO;
            default:                ctl = 12'h000;
          endcase
        end
        T5: begin
          case (OPCODE)
            OP_LDA:         ctl = C_CE | C_LA;
            OP_ADD, OP_SUB: ctl = C_CE | C_LB;
            default:        ctl = 12'h000;
          endcase
        end
        T6: begin
          case (OPCODE)
            OP_ADD:  ctl = C_EU | C_LA;
            OP_SUB:  ctl = C_SU | C_EU | C_LA;
            default: ctl = 12'h000;
          endcase
        end
        default: ctl = 12'h000;
      endcase
    end
  end

  assign T   = ring;
  assign HLT = halted;
  assign {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo} = ctl;

endmodule
